decrypt_sched: RTL and testbench

DECRYPT_SCHED -- requirements
Module: decrypt_sched

---
 rtl/decrypt_pkg.sv | 13 +
 rtl/sched_fifo.sv | 41 ++++
 rtl/decrypt_sched.sv | 117 +++++++++++
 tb/tb_decrypt_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/decrypt_pkg.sv
// decrypt_pkg: shared widths, requester ids and tag type for the decrypt scheduler
package decrypt_pkg;
    localparam int DATA_W          = 65;
    localparam int KEY_W           = 64;
    localparam int ENG_LATENCY_DEF = 2;

    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;

    typedef struct packed {
        logic    v;
        req_id_t id;
    } tag_t;
endpackage

// File: rtl/sched_fifo.sv
// sched_fifo: first-word-fall-through result FIFO with occupancy count
module sched_fifo
    import decrypt_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic [CW-1:0]     count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp, rp;
    logic              wr, rd;

    assign empty = count == '0;
    assign rd    = pop && !empty;
    assign wr    = push && (count != CW'(DEPTH) || rd);
    assign rdata = mem[rp];

    always_ff @(posedge clk)
        if (wr) mem[wp] <= wdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(wr);
            rp    <= rp + AW'(rd);
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/decrypt_sched.sv
// decrypt_sched: credit-based round-robin scheduler of two requesters onto one decrypt engine.
// ENG_LATENCY counts cycles from grant to engine result; DECRYPT_SCHED_STATS_EN adds grant counters.
module decrypt_sched
    import decrypt_pkg::*;
#(
    parameter int ENG_LATENCY = ENG_LATENCY_DEF,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic [DATA_W-1:0] a_req_data,
    input  logic [KEY_W-1:0]  a_req_key,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [DATA_W-1:0] a_rsp_data,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic [DATA_W-1:0] b_req_data,
    input  logic [KEY_W-1:0]  b_req_key,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rsp_data,
    output logic              eng_compute_resq,
    output logic [DATA_W-1:0] eng_encrypt_data,
    output logic [KEY_W-1:0]  eng_key,
    input  logic [DATA_W-1:0] eng_clr_data,
    input  logic              eng_clr_data_valid,
`ifdef DECRYPT_SCHED_STATS_EN
    output logic [15:0]       a_grant_cnt,
    output logic [15:0]       b_grant_cnt,
`endif
    output logic              seq_err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(ENG_LATENCY + 1);

    logic [1:0]           req_v, rsp_rdy, elig, gnt, push, retire, empty;
    logic [1:0][CW-1:0]   occ, infl;
    tag_t                 tag [ENG_LATENCY];
    logic                 prio_b, issue_q, tag_v, drain_on, beat;
    req_id_t              tag_id;
    logic [DW-1:0]        drain;
    logic [DATA_W-1:0]    data_q;
    logic [KEY_W-1:0]     key_q;

    assign req_v    = {b_req_valid, a_req_valid};
    assign rsp_rdy  = {b_rsp_ready, a_rsp_ready};
    assign tag_v    = tag[ENG_LATENCY-1].v;
    assign tag_id   = tag[ENG_LATENCY-1].id;
    assign drain_on = drain != '0;
    assign beat     = !drain_on && tag_v && eng_clr_data_valid;

    // Credit counts results already queued plus those still inside the engine
    for (genvar i = 0; i < 2; i++) begin : g_req
        assign elig[i]   = req_v[i] && (CW+1)'(occ[i]) + (CW+1)'(infl[i]) < (CW+1)'(FIFO_DEPTH);
        assign push[i]   = beat && tag_id == (i == 1 ? REQ_B : REQ_A);
        assign retire[i] = tag_v && tag_id == (i == 1 ? REQ_B : REQ_A);
    end

    assign gnt[0] = reset_n && elig[0] && (!elig[1] || !prio_b);
    assign gnt[1] = reset_n && elig[1] && !gnt[0];

    assign a_req_ready      = gnt[0];
    assign b_req_ready      = gnt[1];
    assign a_rsp_valid      = reset_n && !empty[0];
    assign b_rsp_valid      = reset_n && !empty[1];
    assign eng_compute_resq = reset_n && issue_q;
    assign eng_encrypt_data = reset_n ? data_q : '0;
    assign eng_key          = reset_n ? key_q : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prio_b  <= 1'b0;
            issue_q <= 1'b0;
            data_q  <= '0;
            key_q   <= '0;
            infl    <= '0;
            tag     <= '{default: '0};
            drain   <= DW'(ENG_LATENCY);
            seq_err <= 1'b0;
        end else begin
            if (|gnt) prio_b <= gnt[0];
            issue_q <= |gnt;
            data_q  <= gnt[0] ? a_req_data : gnt[1] ? b_req_data : '0;
            key_q   <= gnt[0] ? a_req_key : gnt[1] ? b_req_key : '0;
            for (int k = 0; k < 2; k++) infl[k] <= infl[k] + CW'(gnt[k]) - CW'(retire[k]);
            tag[0]  <= '{v: |gnt, id: gnt[1] ? REQ_B : REQ_A};
            for (int k = 1; k < ENG_LATENCY; k++) tag[k] <= tag[k-1];
            if (drain_on) drain <= drain - 1'b1;
            if (!drain_on && tag_v != eng_clr_data_valid) seq_err <= 1'b1;
        end
    end

`ifdef DECRYPT_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_grant_cnt <= '0;
            b_grant_cnt <= '0;
        end else begin
            if (gnt[0] && a_grant_cnt != '1) a_grant_cnt <= a_grant_cnt + 1'b1;
            if (gnt[1] && b_grant_cnt != '1) b_grant_cnt <= b_grant_cnt + 1'b1;
        end
    end
`endif

    sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk(clk), .reset_n(reset_n), .push(push[0]), .wdata(eng_clr_data),
        .pop(a_rsp_valid && rsp_rdy[0]), .rdata(a_rsp_data), .empty(empty[0]), .count(occ[0])
    );

    sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk(clk), .reset_n(reset_n), .push(push[1]), .wdata(eng_clr_data),
        .pop(b_rsp_valid && rsp_rdy[1]), .rdata(b_rsp_data), .empty(empty[1]), .count(occ[1])
    );
endmodule

// File: tb/tb_decrypt_sched.sv
// tb_decrypt_sched: directed scoreboard bench for decrypt_sched with a one-register engine model
module tb_decrypt_sched;
    import decrypt_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_req_valid, b_req_valid, a_rsp_ready, b_rsp_ready;
    logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
    logic [64:0] a_req_data, b_req_data, a_rsp_data, b_rsp_data;
    logic [63:0] a_req_key, b_req_key;
    logic        eng_compute_resq, eng_clr_data_valid, seq_err;
    logic [64:0] eng_encrypt_data, eng_clr_data;
    logic [63:0] eng_key;
`ifdef DECRYPT_SCHED_STATS_EN
    logic [15:0] a_grant_cnt, b_grant_cnt;
`endif

    logic        eng_v = 1'b0;
    logic        inj = 1'b0;
    logic [64:0] eng_d = '0;
    logic [64:0] qa[$], qb[$];
    int          checks = 0, failures = 0, ga = 0, gb = 0;

    always #5 clk = ~clk;

    // Engine: result one cycle after the strobe, i.e. two cycles after the grant
    always @(posedge clk) begin
        eng_v <= eng_compute_resq;
        eng_d <= {eng_encrypt_data[64], eng_encrypt_data[63:0] ^ eng_key};
    end
    assign eng_clr_data_valid = eng_v | inj;
    assign eng_clr_data       = inj ? 65'h1_DEAD_BEEF_0000_0001 : eng_d;

    decrypt_sched #(.ENG_LATENCY(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_data(a_req_data), .a_req_key(a_req_key),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_data(b_req_data), .b_req_key(b_req_key),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data),
        .eng_compute_resq(eng_compute_resq), .eng_encrypt_data(eng_encrypt_data), .eng_key(eng_key),
        .eng_clr_data(eng_clr_data), .eng_clr_data_valid(eng_clr_data_valid),
`ifdef DECRYPT_SCHED_STATS_EN
        .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt),
`endif
        .seq_err(seq_err)
    );

    function automatic logic [64:0] dec(input logic [64:0] d, input logic [63:0] k);
        return {d[64], d[63:0] ^ k};
    endfunction

    function automatic logic [64:0] rnd65();
        return {1'($urandom()), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        #1;
        if (a_req_valid && a_req_ready) begin qa.push_back(dec(a_req_data, a_req_key)); ga++; end
        if (b_req_valid && b_req_ready) begin qb.push_back(dec(b_req_data, b_req_key)); gb++; end
        if (a_rsp_valid && a_rsp_ready) begin
            if (qa.size() == 0) chk("a_rsp_spurious", a_rsp_valid, 0);
            else chk("a_rsp_data", a_rsp_data, qa.pop_front());
        end
        if (b_rsp_valid && b_rsp_ready) begin
            if (qb.size() == 0) chk("b_rsp_spurious", b_rsp_valid, 0);
            else chk("b_rsp_data", b_rsp_data, qb.pop_front());
        end
    endtask

    task automatic cyc();
        sample();
        @(negedge clk);
    endtask

    task automatic cycn(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        reset_n = 1'b0;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        a_req_data = '0; b_req_data = '0; a_req_key = '0; b_req_key = '0;
        @(negedge clk);
        a_req_valid = 1'b1; b_req_valid = 1'b1;
        sample();
        chk("rst_a_ready", a_req_ready, 0);
        chk("rst_b_ready", b_req_ready, 0);
        chk("rst_a_rsp", a_rsp_valid, 0);
        chk("rst_b_rsp", b_rsp_valid, 0);
        chk("rst_strobe", eng_compute_resq, 0);
        chk("rst_eng_data", eng_encrypt_data, 0);
        chk("rst_seq_err", seq_err, 0);
        @(negedge clk);
        cycn(2);
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        reset_n = 1'b1;
        cycn(1);

        a_req_valid = 1'b1; a_req_data = 65'h0_1234_5678_9ABC_DEF0; a_req_key = '0;
        sample();
        chk("single_grant", a_req_ready, 1);
        chk("single_b_idle", b_req_ready, 0);
        @(negedge clk);
        a_req_valid = 1'b0;
        sample();
        chk("issue_strobe", eng_compute_resq, 1);
        chk("issue_data", eng_encrypt_data, 65'h0_1234_5678_9ABC_DEF0);
        chk("issue_key", eng_key, 0);
        chk("rsp_early1", a_rsp_valid, 0);
        @(negedge clk);
        sample();
        chk("rsp_early2", a_rsp_valid, 0);
        chk("idle_strobe", eng_compute_resq, 0);
        chk("idle_data", eng_encrypt_data, 0);
        @(negedge clk);
        sample();
        chk("rsp_latency", a_rsp_valid, 1);
        chk("rsp_value", a_rsp_data, 65'h0_1234_5678_9ABC_DEF0);
        @(negedge clk);
        cycn(2);
        chk("single_drained", qa.size(), 0);

        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        a_req_valid = 1'b1; b_req_valid = 1'b1;
        a_req_key = {$urandom(), $urandom()}; b_req_key = {$urandom(), $urandom()};
        for (int i = 0; i < 16; i++) begin
            a_req_data = rnd65(); b_req_data = rnd65();
            sample();
            chk("alt_a", a_req_ready, 65'(i % 2 == 0));
            chk("alt_b", b_req_ready, 65'(i % 2 == 1));
            @(negedge clk);
        end
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        sample();
`ifdef DECRYPT_SCHED_STATS_EN
        chk("a_grant_cnt", a_grant_cnt, 8);
        chk("b_grant_cnt", b_grant_cnt, 8);
`endif
        @(negedge clk);
        cycn(5);
        chk("alt_drain_a", qa.size(), 0);
        chk("alt_drain_b", qb.size(), 0);

        b_rsp_ready = 1'b0; a_req_valid = 1'b1; b_req_valid = 1'b1; gb = 0;
        for (int i = 0; i < 20; i++) begin
            a_req_data = rnd65(); b_req_data = rnd65();
            sample();
            if (i >= 10) begin
                chk("bp_a_stream", a_req_ready, 1);
                chk("bp_b_blocked", b_req_ready, 0);
            end
            @(negedge clk);
        end
        chk("bp_b_grants", gb, 4);
        a_req_valid = 1'b0;
        cycn(4);

        gb = 0; b_req_data = rnd65();
        sample();
        chk("full_valid", b_rsp_valid, 1);
        chk("full_blocked", b_req_ready, 0);
        @(negedge clk);
        b_rsp_ready = 1'b1;
        sample();
        chk("full_pop_blocked", b_req_ready, 0);
        @(negedge clk);
        b_rsp_ready = 1'b0; b_req_data = rnd65();
        sample();
        chk("credit_return", b_req_ready, 1);
        @(negedge clk);
        b_req_valid = 1'b0;
        cycn(4);
        chk("full_one_grant", gb, 1);
        b_rsp_ready = 1'b1;
        cycn(6);
        chk("full_drain_b", qb.size(), 0);
        chk("full_drain_a", qa.size(), 0);

        a_req_valid = 1'b1; a_req_data = rnd65();
        cyc();
        a_req_data = rnd65();
        cyc();
        a_req_valid = 1'b0; reset_n = 1'b0;
        qa.delete(); qb.delete();
        sample();
        chk("midrst_rsp", a_rsp_valid, 0);
        chk("midrst_strobe", eng_compute_resq, 0);
        @(negedge clk);
        reset_n = 1'b1; inj = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample();
            chk("post_rst_a", a_rsp_valid, 0);
            chk("post_rst_b", b_rsp_valid, 0);
            @(negedge clk);
            inj = 1'b0;
        end
        chk("post_rst_seq_err", seq_err, 0);

        inj = 1'b1;
        cyc();
        inj = 1'b0;
        sample();
        chk("seq_err_set", seq_err, 1);
        chk("inj_dropped", a_rsp_valid | b_rsp_valid, 0);
        @(negedge clk);
        cycn(3);
        chk("seq_err_sticky", seq_err, 1);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        sample();
        chk("seq_err_cleared", seq_err, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
